// File: rtl/tib_loader_if.sv
// Console loader bus bundle: character input stream, byte write port to
// memory, and the line handoff to the outer interpreter.
interface tib_loader_if #(
    parameter int unsigned A_W = 32
);
    logic           rx_vld;
    logic [7:0]     rx_dat;
    logic           rx_rdy;
    logic           mem_we;
    logic [A_W-1:0] mem_a;
    logic [7:0]     mem_d;
    logic           mem_gnt;
    logic           line_vld;
    logic [15:0]    line_len;
    logic           line_ack;
    logic           ovf;

    // Loader side: consumes characters, drives the memory bus and the line handoff.
    modport master (
        input  rx_vld, rx_dat, mem_gnt, line_ack,
        output rx_rdy, mem_we, mem_a, mem_d, line_vld, line_len, ovf
    );

    // Environment side: terminal source, memory, interpreter.
    modport slave (
        output rx_vld, rx_dat, mem_gnt, line_ack,
        input  rx_rdy, mem_we, mem_a, mem_d, line_vld, line_len, ovf
    );
endinterface

// File: rtl/tib_loader.sv
// Terminal input buffer loader: edits a typed character stream into a
// 0x00-terminated line at TIB and hands it to the interpreter.
module tib_loader #(
    parameter int unsigned TIB    = 'h1000,
    parameter int unsigned TIB_SZ = 'h100,
    parameter int unsigned A_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    tib_loader_if.master bus
);
    localparam int unsigned      CNT_W   = $clog2(TIB_SZ);
    // Highest offset a printable character may occupy; the last byte is kept for the terminator.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIB_SZ - 1);

    typedef enum logic [1:0] {
        S_RX,
        S_WR,
        S_TERM,
        S_RDY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cr_seen;

    logic [7:0] ch;
    logic       is_cr;
    logic       is_lf;
    logic       is_bs;
    logic       is_print;

    // Classify the incoming character; tab is folded into a space before the printable test.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
        ch       = (bus.rx_dat == 8'h09) ? 8'h20 : bus.rx_dat;
        is_cr    = (bus.rx_dat == 8'h0D);
        is_lf    = (bus.rx_dat == 8'h0A);
        is_bs    = (bus.rx_dat == 8'h08) || (bus.rx_dat == 8'h7F);
        is_print = (ch >= 8'h20) && (ch <= 8'h7E);
    end

    // Line-editing FSM with all bus and handoff outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state        <= S_RX;
            cnt          <= '0;
            cr_seen      <= 1'b0;
            bus.rx_rdy   <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_d    <= '0;
            bus.line_vld <= 1'b0;
            bus.line_len <= '0;
            bus.ovf      <= 1'b0;
        end else begin
            case (state)
                S_RX: begin
                    if (bus.rx_vld) begin
                        // Only a CR arms LF suppression; anything else disarms it.
                        cr_seen <= is_cr;
                        if (is_cr || (is_lf && !cr_seen)) begin
                            state      <= S_TERM;
                            bus.rx_rdy <= 1'b0;
                            bus.mem_we <= 1'b1;
                            bus.mem_a  <= A_W'(TIB) + A_W'(cnt);
                            bus.mem_d  <= 8'h00;
                        end else if (is_bs) begin
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end
                        end else if (is_print) begin
                            if (cnt < CNT_MAX) begin
                                state      <= S_WR;
                                bus.rx_rdy <= 1'b0;
                                bus.mem_we <= 1'b1;
                                bus.mem_a  <= A_W'(TIB) + A_W'(cnt);
                                bus.mem_d  <= ch;
                            end else begin
                                bus.ovf <= 1'b1;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (bus.mem_gnt) begin
                        state      <= S_RX;
                        cnt        <= cnt + 1'b1;
                        bus.mem_we <= 1'b0;
                        bus.rx_rdy <= 1'b1;
                    end
                end
                S_TERM: begin
                    if (bus.mem_gnt) begin
                        state        <= S_RDY;
                        bus.mem_we   <= 1'b0;
                        bus.line_vld <= 1'b1;
                        bus.line_len <= 16'(cnt);
                    end
                end
                S_RDY: begin
                    // cr_seen is deliberately kept so an LF arriving after the handoff is still dropped.
                    if (bus.line_ack) begin
                        state        <= S_RX;
                        cnt          <= '0;
                        bus.ovf      <= 1'b0;
                        bus.line_vld <= 1'b0;
                        bus.rx_rdy   <= 1'b1;
                    end
                end
                default: state <= S_RX;
            endcase
        end
    end
endmodule

// File: tb/tb_tib_loader.sv
// Directed bench for tib_loader: per-character vector table plus hand-written
// sequences for overflow, bus stall, idle ack and reset during a stalled write.
module tb_tib_loader;
    localparam int unsigned TIB    = 'h1000;
    localparam int unsigned TIB_SZ = 'h100;
    localparam int unsigned A_W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tib_loader_if #(.A_W(A_W)) bus ();

    tib_loader #(.TIB(TIB), .TIB_SZ(TIB_SZ), .A_W(A_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wr_q[$];

    // Memory model: log every granted byte write.
    always @(posedge clk) begin
        if (rst && bus.mem_we && bus.mem_gnt) begin
            wr_q.push_back('{bus.mem_a, bus.mem_d});
        end
    end

    typedef struct {
        logic [7:0]  ch;
        int          nwr;
        logic [31:0] off;
        logic [7:0]  d;
        bit          hand;
        logic [15:0] len;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [7:0] ch, input int nwr, input logic [31:0] off,
                                input logic [7:0] d, input bit hand, input logic [15:0] len);
        vec_t v;
        v.ch = ch; v.nwr = nwr; v.off = off; v.d = d; v.hand = hand; v.len = len;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_char(input logic [7:0] c);
        int k;
        k = 0;
        while (!bus.rx_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.rx_rdy) check("rx_rdy_wait", bus.rx_rdy, 1'b1);
        bus.rx_vld = 1'b1;
        bus.rx_dat = c;
        @(negedge clk);
        bus.rx_vld = 1'b0;
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (!(bus.rx_rdy || bus.line_vld) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!(bus.rx_rdy || bus.line_vld)) check("settle", bus.rx_rdy | bus.line_vld, 1'b1);
    endtask

    task automatic ack_line(input string tag);
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
        check({tag, "_ack_vld"}, bus.line_vld, 1'b0);
        check({tag, "_ack_rdy"}, bus.rx_rdy, 1'b1);
        check({tag, "_ack_ovf"}, bus.ovf, 1'b0);
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int n0;
        int bad;

        bus.rx_vld   = 1'b0;
        bus.rx_dat   = 8'h00;
        bus.mem_gnt  = 1'b1;
        bus.line_ack = 1'b0;

        // "DUP" CR
        vt.push_back(mk(8'h44, 1, 0, 8'h44, 0, 0));
        vt.push_back(mk(8'h55, 1, 1, 8'h55, 0, 0));
        vt.push_back(mk(8'h50, 1, 2, 8'h50, 0, 0));
        vt.push_back(mk(8'h0D, 1, 3, 8'h00, 1, 3));
        // "AB" BS "C" CR
        vt.push_back(mk(8'h41, 1, 0, 8'h41, 0, 0));
        vt.push_back(mk(8'h42, 1, 1, 8'h42, 0, 0));
        vt.push_back(mk(8'h08, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(8'h43, 1, 1, 8'h43, 0, 0));
        vt.push_back(mk(8'h0D, 1, 2, 8'h00, 1, 2));
        // BS at start, then CR LF CR: two empty lines
        vt.push_back(mk(8'h08, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(8'h0D, 1, 0, 8'h00, 1, 0));
        vt.push_back(mk(8'h0A, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(8'h0D, 1, 0, 8'h00, 1, 0));
        // tab, control filtering, DEL, printable bounds, bare LF ends line
        vt.push_back(mk(8'h09, 1, 0, 8'h20, 0, 0));
        vt.push_back(mk(8'h01, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(8'h7F, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(8'h5A, 1, 0, 8'h5A, 0, 0));
        vt.push_back(mk(8'h1F, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(8'h20, 1, 1, 8'h20, 0, 0));
        vt.push_back(mk(8'h7E, 1, 2, 8'h7E, 0, 0));
        vt.push_back(mk(8'h1B, 0, 0, 8'h00, 0, 0));
        vt.push_back(mk(8'h0A, 1, 3, 8'h00, 1, 3));
        // LF right after an LF-terminated line is its own empty line
        vt.push_back(mk(8'h0A, 1, 0, 8'h00, 1, 0));

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rx_rdy", bus.rx_rdy, 1'b1);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_d", bus.mem_d, 8'h00);
        check("rst_line_vld", bus.line_vld, 1'b0);
        check("rst_line_len", bus.line_len, 16'h0);
        check("rst_ovf", bus.ovf, 1'b0);

        // Vector table
        foreach (vt[i]) begin
            n0 = wr_q.size();
            send_char(vt[i].ch);
            settle();
            check($sformatf("v%0d_nwr", i), wr_q.size() - n0, vt[i].nwr);
            if (vt[i].nwr == 1 && wr_q.size() > n0) begin
                check($sformatf("v%0d_addr", i), wr_q[$].a, TIB + vt[i].off);
                check($sformatf("v%0d_data", i), wr_q[$].d, vt[i].d);
            end
            check($sformatf("v%0d_line_vld", i), bus.line_vld, vt[i].hand);
            check($sformatf("v%0d_ovf", i), bus.ovf, 1'b0);
            if (vt[i].hand) begin
                check($sformatf("v%0d_len", i), bus.line_len, vt[i].len);
                check($sformatf("v%0d_rdy_low", i), bus.rx_rdy, 1'b0);
                ack_line($sformatf("v%0d", i));
            end
        end

        // line_ack while no line is pending must not reset the write offset
        send_char(8'h4B);
        settle();
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
        check("idle_ack_vld", bus.line_vld, 1'b0);
        send_char(8'h4C);
        settle();
        check("idle_ack_addr", wr_q[$].a, TIB + 1);
        check("idle_ack_data", wr_q[$].d, 8'h4C);
        send_char(8'h0D);
        settle();
        check("idle_ack_len", bus.line_len, 16'd2);
        ack_line("idle_ack");

        // Overflow: 300 chars into a 255-char line
        n0 = wr_q.size();
        for (int i = 0; i < 300; i++) begin
            send_char(8'h78);
            settle();
            if (i == 254) check("ovf_not_yet", bus.ovf, 1'b0);
            if (i == 255) check("ovf_set", bus.ovf, 1'b1);
        end
        check("ovf_nwr", wr_q.size() - n0, 255);
        bad = 0;
        for (int j = 0; j < 255 && n0 + j < wr_q.size(); j++) begin
            if (wr_q[n0 + j].a !== TIB + j || wr_q[n0 + j].d !== 8'h78) bad++;
        end
        check("ovf_addr_seq", bad, 0);
        check("ovf_last_addr", wr_q[$].a, TIB + 'hFE);
        send_char(8'h0D);
        settle();
        check("ovf_term_addr", wr_q[$].a, TIB + 'hFF);
        check("ovf_term_data", wr_q[$].d, 8'h00);
        check("ovf_len", bus.line_len, 16'hFF);
        check("ovf_line_vld", bus.line_vld, 1'b1);
        check("ovf_sticky", bus.ovf, 1'b1);
        ack_line("ovf");

        // Stall WR for 5 cycles
        bus.mem_gnt = 1'b0;
        n0 = wr_q.size();
        send_char(8'h51);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_we", k), bus.mem_we, 1'b1);
            check($sformatf("stall%0d_a", k), bus.mem_a, TIB);
            check($sformatf("stall%0d_d", k), bus.mem_d, 8'h51);
            check($sformatf("stall%0d_rdy", k), bus.rx_rdy, 1'b0);
            @(negedge clk);
        end
        check("stall_no_write", wr_q.size() - n0, 0);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        check("stall_one_write", wr_q.size() - n0, 1);
        check("stall_rdy_back", bus.rx_rdy, 1'b1);
        check("stall_we_low", bus.mem_we, 1'b0);

        // Reset during a stalled terminator write
        bus.mem_gnt = 1'b0;
        send_char(8'h0D);
        check("term_stall_we", bus.mem_we, 1'b1);
        check("term_stall_a", bus.mem_a, TIB + 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("term_rst_we", bus.mem_we, 1'b0);
        check("term_rst_vld", bus.line_vld, 1'b0);
        check("term_rst_a", bus.mem_a, 32'h0);
        rst = 1'b1;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        n0 = wr_q.size();
        send_char(8'h31);
        settle();
        check("post_rst_addr", wr_q[$].a, TIB);
        check("post_rst_data", wr_q[$].d, 8'h31);
        send_char(8'h0D);
        settle();
        check("post_rst_nwr", wr_q.size() - n0, 2);
        check("post_rst_term", wr_q[$].a, TIB + 1);
        check("post_rst_len", bus.line_len, 16'd1);
        check("post_rst_vld", bus.line_vld, 1'b1);
        ack_line("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tib_loader.md
# tib_loader

Console line loader that feeds the eJ32 outer interpreter its terminal input buffer (TIB). It accepts a byte stream of typed characters, applies line editing (backspace, tab expansion, control-character filtering, CR/LF handling), and writes the edited line byte-by-byte into memory at TIB over the 8-bit data bus. On end-of-line it writes a 0x00 terminator and hands the line to the interpreter with a valid/ack handshake. It sits directly upstream of the core's input-parsing path, replacing the pre-loaded TIB image during interactive runs.

## Interface

- TIB, 'h1000, byte address of the input buffer base
- TIB_SZ, 'h100, buffer size in bytes including the terminator (power of two, ≥ 4)
- A_W, 32, memory address width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- rx_vld  in  1  input character valid
- rx_dat  in  8  input character
- rx_rdy  out  1  loader ready to accept a character
- mem_we  out  1  byte write request
- mem_a  out  A_W  write address
- mem_d  out  8  write data
- mem_gnt  in  1  write accepted this cycle
- line_vld  out  1  completed line available in TIB
- line_len  out  16  line length in bytes, terminator excluded
- line_ack  in  1  interpreter has consumed the line
- ovf  out  1  sticky: characters dropped since last line handoff

## Operation

- States: RX (await char), WR (byte write pending), TERM (terminator write pending), RDY (line handed off).
- Internal: cnt (write offset, 0..TIB_SZ-1), cr_seen (last accepted char was CR).
- RX: rx_rdy=1. On rx_vld, classify rx_dat:
  - 0x0D: cr_seen←1, go TERM.
  - 0x0A: if cr_seen, cr_seen←0 and ignore; else go TERM.
  - 0x08 or 0x7F: if cnt>0, cnt←cnt-1; no write; stay RX.
  - 0x09: treated as 0x20.
  - other <0x20: dropped silently.
  - printable (0x20..0x7E, and tab-mapped 0x20): if cnt < TIB_SZ-1, latch mem_a=TIB+cnt, mem_d=char, go WR; else drop and set ovf.
  - Any char other than 0x0D clears cr_seen.
- WR: mem_we=1, mem_a/mem_d held stable; on mem_gnt, cnt←cnt+1, go RX.
- TERM: mem_we=1, mem_a=TIB+cnt, mem_d=0x00; on mem_gnt, line_len←cnt, go RDY.
- RDY: line_vld=1, line_len stable, rx_rdy=0. On line_ack: cnt←0, ovf←0, go RX. cr_seen retained so a CR-LF split across the handoff still drops the LF.
- Last buffer byte (offset TIB_SZ-1) is reserved for the terminator; line_len max TIB_SZ-1.
- Empty line (CR at cnt=0) is valid: writes 0x00 at TIB, line_len=0.
- Backspace past start (cnt=0) has no effect and does not set ovf.

## Timing

- Reset (rst=0 sampled at a rising edge): state RX, cnt=0, cr_seen=0; outputs rx_rdy=1 after reset deasserts, mem_we=0, mem_a=0, mem_d=0, line_vld=0, line_len=0, ovf=0. A pending write is abandoned; no partial handshake survives.
- Character accepted on the edge where rx_vld & rx_rdy. rx_rdy is registered-state decode: 0 during WR, TERM, RDY.
- mem_we rises the cycle after the accepting edge; with mem_gnt tied high a printable char costs 2 cycles (RX, WR); sustained throughput one char per 2 cycles.
- mem_gnt low stalls WR/TERM indefinitely with address/data stable; mem_gnt ignored when mem_we=0.
- line_vld rises the cycle after TERM's granted edge; falls the cycle after line_ack sampled high; rx_rdy=1 in that same cycle.
- line_ack while line_vld=0 is ignored.
- Edited characters (BS/filtered) take 1 cycle, no bus activity.

## Test plan

- Reset, send "DUP" then 0x0D, mem_gnt=1 -> writes 'h44@1000, 'h55@1001, 'h50@1002, 'h00@1003; line_vld=1, line_len=3; ack -> rx_rdy=1, cnt=0.
- Send "AB",0x08,"C",0x0D -> bytes 'h41@1000, 'h43@1001, 'h00@1002; line_len=2; 0x08 at cnt=0 on next line -> no write.
- Send 0x0D,0x0A,0x0D with acks between -> exactly two empty lines (line_len=0 each), LF produces no handoff.
- TIB_SZ='h100, send 300 'x' then 0x0D -> 255 writes 'h1000..'h10FE, 0x00 @'h10FF, line_len='hFF, ovf=1; clears on line_ack.
- mem_gnt held low 5 cycles during WR -> mem_we, mem_a, mem_d stable, rx_rdy=0; char written once when gnt rises.
- Assert rst=0 during TERM stall -> next cycle mem_we=0, line_vld=0, cnt=0; subsequent "1",0x0D writes '1'@1000.
